fetch_unit: RTL and testbench

Instruction fetch stage, directly upstream of the decoder. Keeps the fetch PC and issues in-order word requests to instruction memory. Buffers returned instructions in a small FIFO and presents them, tagged with their PC, to the decoder over a valid/ready handshake. A redirect from the branch/jump path flushes everything in flight and restarts fetch at the target.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests, tagged instruction
// buffer towards the decoder, redirect flush with response discard.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);
    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

    fetch_state_e        state_q;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [CW-1:0]       out_q, out_d;
    logic [CW-1:0]       disc_q, disc_d;

    logic                req_fire, push, pop, drop;
    logic [CW-1:0]       buf_cnt;
    logic                buf_empty;
    logic [ILEN+XLEN-1:0] buf_dout;
    logic [XLEN-1:0]     tag_pc;

    logic                buf_full_unused;
    logic                tag_full_unused;
    logic                tag_empty_unused;
    logic [CW-1:0]       tag_cnt_unused;

    // Credit covers words in flight plus words already buffered, so a push never overflows.
    assign imem_req_valid = (state_q == RUN) && (({1'b0, out_q} + {1'b0, buf_cnt}) < CAP);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign drop = imem_resp_valid && (disc_q != '0);
    assign push = imem_resp_valid && !drop && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid      = !buf_empty;
    assign {inst, inst_pc} = buf_dout;

    always_comb begin
        out_d  = out_q + CW'(req_fire) - CW'(imem_resp_valid);
        pc_d   = req_fire ? pc_q + PC_STEP : pc_q;
        disc_d = drop ? disc_q - CW'(1) : disc_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~XLEN'(3);
            disc_d = out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                default: state_q <= RUN;
            endcase
            pc_q   <= pc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ILEN + XLEN)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({imem_resp_data, tag_pc}),
        .data_o  (buf_dout),
        .full_o  (buf_full_unused),
        .empty_o (buf_empty),
        .count_o (buf_cnt)
    );

    // Tags are never flushed: every response, kept or discarded, retires one.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .pop_i   (imem_resp_valid),
        .data_i  (pc_q),
        .data_o  (tag_pc),
        .full_o  (tag_full_unused),
        .empty_o (tag_empty_unused),
        .count_o (tag_cnt_unused)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a memory model and a program-order scoreboard.
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int ready_pct = 100, irdy_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
    bit          rd_req = 1'b0;
    logic [31:0] rd_target = '0;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = -1;
    logic [31:0] exp_pc = RESET_PC, exp_req = RESET_PC;
    bit          prev_redirect = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    int          n_deliv = 0;
    logic [31:0] last_deliv_pc = '0;
    bit          s_fire, s_inst_valid, s_req_valid;
    logic [31:0] s_fire_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: check, drive this cycle's inputs, then advance the model.
    task automatic step();
        int          lat, due;
        logic [31:0] a;
        @(negedge clk);
        cyc++;
        s_inst_valid = inst_valid;
        s_req_valid  = imem_req_valid;
        if (prev_redirect) begin
            n_checks++;
            if (inst_valid !== 1'b0) $display("FAIL redirect_flush: inst_valid=%b required 0", inst_valid);
            else n_pass++;
        end
        if (prev_stall) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr)
                $display("FAIL req_hold: valid=%b addr=%h required 1/%h", imem_req_valid, imem_req_addr, prev_addr);
            else n_pass++;
        end
        if (imem_req_valid === 1'b1) begin
            n_checks++;
            if (pend_addr.size() >= DEPTH) $display("FAIL credit: outstanding=%0d with req_valid, required <%0d", pend_addr.size(), DEPTH);
            else n_pass++;
        end

        imem_req_ready = ($urandom_range(99) < ready_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            a = pend_addr.pop_front();
            pend_due.delete(0);
            imem_resp_valid = 1'b1;
            imem_resp_data  = memf(a);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        if (!rd_req && redir_pct != 0 && $urandom_range(99) < redir_pct) begin
            rd_req    = 1'b1;
            rd_target = $urandom;
        end
        redirect_valid = rd_req;
        redirect_pc    = rd_target;
        rd_req         = 1'b0;

        s_fire      = imem_req_valid && imem_req_ready;
        s_fire_addr = imem_req_addr;
        if (s_fire) begin
            n_checks++;
            if (imem_req_addr !== exp_req) $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_req);
            else n_pass++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(due);
            last_due = due;
            exp_req  = exp_req + 32'd4;
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            n_checks++;
            if (inst_pc !== exp_pc || inst !== memf(exp_pc))
                $display("FAIL deliver: pc=%h inst=%h required pc=%h inst=%h", inst_pc, inst, exp_pc, memf(exp_pc));
            else n_pass++;
            exp_pc        = exp_pc + 32'd4;
            last_deliv_pc = inst_pc;
            n_deliv++;
        end
        if (redirect_valid) begin
            exp_pc  = redirect_pc & ~32'h3;
            exp_req = redirect_pc & ~32'h3;
        end
        prev_redirect = redirect_valid;
        prev_stall    = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr     = imem_req_addr;
    endtask

    task automatic assert_reset();
        #2;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        last_due      = -1;
        exp_pc        = RESET_PC;
        exp_req       = RESET_PC;
        prev_redirect = 1'b0;
        prev_stall    = 1'b0;
        rd_req        = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic test_reset();
        assert_reset();
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== RESET_PC) $display("FAIL rst_req_addr: got %h required %h", imem_req_addr, RESET_PC); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b required 0", inst_valid); else n_pass++;
        n_checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h required 0", inst); else n_pass++;
        n_checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h required 0", inst_pc); else n_pass++;
        release_reset();
    endtask

    task automatic test_boot_stream();
        int          first_valid = -1;
        logic [31:0] first_pc = '1;
        int          n0;
        ready_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        n0 = n_deliv;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cyc == 0) begin
                n_checks++;
                if (s_req_valid !== 1'b0) $display("FAIL boot_no_req: req_valid=%b required 0", s_req_valid); else n_pass++;
            end
            if (cyc == 1) begin
                n_checks++;
                if (!s_fire || s_fire_addr !== RESET_PC) $display("FAIL first_req: fire=%b addr=%h required 1/%h", s_fire, s_fire_addr, RESET_PC); else n_pass++;
            end
            if (cyc == 2) begin
                n_checks++;
                if (!s_fire || s_fire_addr !== RESET_PC + 32'd4) $display("FAIL second_req: fire=%b addr=%h required 1/%h", s_fire, s_fire_addr, RESET_PC + 32'd4); else n_pass++;
            end
            if (first_valid < 0 && s_inst_valid) begin
                first_valid = cyc;
                first_pc    = inst_pc;
            end
        end
        n_checks++; if (first_valid != 3) $display("FAIL first_valid_cycle: got %0d required 3", first_valid); else n_pass++;
        n_checks++; if (first_pc !== RESET_PC) $display("FAIL first_inst_pc: got %h required %h", first_pc, RESET_PC); else n_pass++;
        n_checks++; if (n_deliv - n0 < 6) $display("FAIL boot_rate: delivered %0d required >=6", n_deliv - n0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int nf = 0;
        int n0;
        irdy_pct = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_fire) nf++;
        end
        n_checks++; if (nf > DEPTH) $display("FAIL stall_reqs: issued %0d required <=%0d", nf, DEPTH); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b required 0", imem_req_valid); else n_pass++;
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL stall_inst_valid: got %b required 1", inst_valid); else n_pass++;
        irdy_pct = 100;
        n0 = n_deliv;
        repeat (20) step();
        n_checks++; if (n_deliv - n0 < 10) $display("FAIL resume_rate: delivered %0d required >=10", n_deliv - n0); else n_pass++;
    endtask

    task automatic test_redirect_drop();
        int n0;
        bit got = 1'b0;
        ready_pct = 100; irdy_pct = 100; lat_min = 6; lat_max = 6; redir_pct = 0;
        assert_reset();
        release_reset();
        step();
        ready_pct = 0; rd_req = 1'b1; rd_target = 32'h10;
        step();
        ready_pct = 100;
        step();
        step();
        n_checks++; if (!s_fire || s_fire_addr !== 32'h14) $display("FAIL drop_setup: fire=%b addr=%h required 1/00000014", s_fire, s_fire_addr); else n_pass++;
        rd_req = 1'b1; rd_target = 32'h103;
        n0 = n_deliv;
        step();
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (n_deliv != n0) got = 1'b1;
        end
        n_checks++;
        if (!got) $display("FAIL drop_timeout: no delivery, required pc 00000100");
        else if (last_deliv_pc !== 32'h100) $display("FAIL drop_next_pc: got %h required 00000100", last_deliv_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_coincident();
        int          n0;
        bit          got = 1'b0;
        logic [31:0] tgt;
        ready_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        assert_reset();
        release_reset();
        step();
        step();
        tgt = $urandom | 32'h0000_0001;
        rd_req = 1'b1; rd_target = tgt;
        n0 = n_deliv;
        step();
        n_checks++; if (!s_fire) $display("FAIL coinc_setup: fire=%b required 1", s_fire); else n_pass++;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (n_deliv != n0) got = 1'b1;
        end
        n_checks++;
        if (!got) $display("FAIL coinc_timeout: no delivery, required pc %h", tgt & ~32'h3);
        else if (last_deliv_pc !== (tgt & ~32'h3)) $display("FAIL coinc_next_pc: got %h required %h", last_deliv_pc, tgt & ~32'h3);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] log_q[$];
        bit          seen0 = 1'b0;
        rd_req = 1'b1; rd_target = 32'hFFFF_FFF8;
        step();
        for (int i = 0; i < 20 && !seen0; i++) begin
            step();
            if (s_fire) log_q.push_back(s_fire_addr);
            if (n_deliv > 0 && last_deliv_pc === 32'h0) seen0 = 1'b1;
        end
        n_checks++;
        if (log_q.size() < 3) $display("FAIL wrap_reqs: got %0d requests required >=3", log_q.size());
        else if (log_q[1] !== 32'hFFFF_FFFC || log_q[2] !== 32'h0) $display("FAIL wrap_addr: got %h,%h required fffffffc,00000000", log_q[1], log_q[2]);
        else n_pass++;
        n_checks++; if (!seen0) $display("FAIL wrap_deliver: pc 0 not delivered, last %h", last_deliv_pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        ready_pct = 100; irdy_pct = 0; lat_min = 1; lat_max = 1; redir_pct = 0;
        assert_reset();
        release_reset();
        step();
        step();
        ready_pct = 0;
        step();
        step();
        n_checks++; if (!s_req_valid || !s_inst_valid) $display("FAIL mid_setup: req_valid=%b inst_valid=%b required 1/1", s_req_valid, s_inst_valid); else n_pass++;
        assert_reset();
        #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL mid_inst_valid: got %b required 0", inst_valid); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL mid_req_valid: got %b required 0", imem_req_valid); else n_pass++;
        release_reset();
        ready_pct = 100; irdy_pct = 100;
        step();
        n_checks++; if (s_req_valid !== 1'b0) $display("FAIL mid_boot: req_valid=%b required 0", s_req_valid); else n_pass++;
        step();
        n_checks++; if (!s_fire || s_fire_addr !== RESET_PC) $display("FAIL mid_refetch: fire=%b addr=%h required 1/%h", s_fire, s_fire_addr, RESET_PC); else n_pass++;
    endtask

    task automatic test_random();
        int n0;
        ready_pct = 70; irdy_pct = 60; lat_min = 1; lat_max = 4; redir_pct = 4;
        repeat (800) step();
        redir_pct = 0; ready_pct = 100; irdy_pct = 100;
        n0 = n_deliv;
        repeat (30) step();
        n_checks++; if (n_deliv - n0 < 12) $display("FAIL drain_progress: delivered %0d required >=12", n_deliv - n0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_boot_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
